bus_op_fifo: RTL and testbench
==============================

Name: bus_op_fifo

Overview:
Parametrised successor to the team's 8-bit bus-in/bus-out block. It applies a per-word operation to the input bus (pass, invert, accumulate, rotate) and buffers the results in a DEPTH-entry FIFO. Valid/ready handshake on both sides. Sits between a bus producer and a consumer that may stall.

Parameters:
WIDTH, 8, data bus width in bits (>=2)
DEPTH, 4, FIFO entries (power of two, >=2)

Ports:
clk  input  1  single clock, all logic rising-edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  producer offers in_data/in_op
in_ready  output  1  block can accept a word this cycle
in_op  input  2  operation: 00 PASS, 01 INV, 10 ACC, 11 ROTL
in_data  input  WIDTH  input bus word
acc_clr  input  1  synchronous clear of accumulator
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer accepts head this cycle
out_data  output  WIDTH  FIFO head word
count  output  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset (rst high at edge): FIFO empty, pointers 0, all entries 0, acc 0, count 0, out_valid 0, out_data 0. in_ready = !full && !rst, so it is 0 while rst is high.
- Push = in_valid && in_ready. Pop = out_valid && out_ready. out_valid = (count != 0).
- Operation on push, computed combinationally and stored in the FIFO:
  - PASS: result = in_data.
  - INV: result = ~in_data.
  - ROTL: result = {in_data[WIDTH-2:0], in_data[WIDTH-1]}.
  - ACC: acc_next = acc + in_data, mod 2^WIDTH with carry dropped. result = acc_next; acc <= acc_next.
- acc is modified only by ACC pushes, acc_clr and rst.
- acc_clr: acc <= 0 at the edge.
  - acc_clr with an ACC push in the same cycle: clear applies first. result = in_data, acc <= in_data.
  - acc_clr never affects FIFO contents.
- Latency: a word accepted at edge N is visible on out_data with out_valid=1 after edge N (registered). There is no same-cycle bypass.
- FIFO order is strict; out_data always shows the head entry.
- Full (count==DEPTH): in_ready=0, so no push is possible even if a pop happens in the same cycle. in_ready rises the cycle after a pop.
- Empty: out_valid=0. A push on an empty FIFO raises out_valid the next cycle.
- Simultaneous push and pop (0<count<DEPTH): count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Holding rules:
  - in_valid with in_ready=0: nothing is consumed and acc does not change.
  - out_data/out_valid remain stable while out_valid && !out_ready.
- rst mid-operation: all buffered words are discarded and acc is cleared, regardless of in-flight handshakes.

Decomposition:
- Package bus_op_pkg:
  - op encodings: OP_PASS=2'b00, OP_INV=2'b01, OP_ACC=2'b10, OP_ROTL=2'b11.
  - a function computing result and acc_next from (op, data, acc, clr).
- Sub-module sync_fifo (WIDTH, DEPTH) holds storage, pointers, count, full/empty.
- The top level holds the op datapath, acc register and handshake glue.

Test Plan:
(WIDTH=8, DEPTH=4)
1. Reset: rst high 2 cycles -> out_valid=0, count=0, in_ready=0. The cycle after rst falls -> in_ready=1.
2. PASS/INV/ROTL, out_ready=1:
   - Stimulus: push {PASS 0xA5}, {INV 0xA5}, {ROTL 0x81} on consecutive cycles.
   - Response: out_data 0xA5, 0x5A, 0x03, each appearing one cycle after its acceptance.
3. ACC wrap:
   - Stimulus: acc_clr, then ACC 0xF0, then ACC 0x20.
   - Response: outputs 0xF0, 0x10; acc=0x10.
4. Full/backpressure:
   - Stimulus: out_ready=0, in_valid held with PASS 0x01..0x05.
   - Response: 0x01..0x04 accepted, count=4, in_ready=0, 0x05 held. Then out_ready=1 for one cycle -> 0x01 popped, count=3, in_ready=1 next cycle, 0x05 accepted after.
5. Simultaneous push/pop at count=2 -> count stays 2, output order preserved.
6. Clear collision and mid-operation reset:
   - acc=0x10, then acc_clr together with ACC 0x07 -> output 0x07, acc=0x07.
   - With count=3, assert rst -> next cycle count=0, out_valid=0, and a following ACC 0x01 yields 0x01.

Source files
------------

// File: rtl/bus_op_pkg.sv
// rtl/bus_op_pkg.sv - operation encodings and the per-word op/accumulate function
package bus_op_pkg;

    // Widest data bus the shared op function supports; callers zero-extend into it.
    localparam int unsigned MAX_W = 64;

    typedef enum logic [1:0] {
        OP_PASS = 2'b00,
        OP_INV  = 2'b01,
        OP_ACC  = 2'b10,
        OP_ROTL = 2'b11
    } op_e;

    typedef struct packed {
        logic [MAX_W-1:0] result;
        logic [MAX_W-1:0] acc_next;
    } op_res_t;

    // Computes the stored word and the accumulator value that an accepted word
    // would produce. The clear is applied before the add, so a clear arriving
    // with an ACC word starts the sum from zero. For non-ACC words acc_next is
    // the accumulator after any clear.
    function automatic op_res_t apply_op(
        input op_e              op,
        input logic [MAX_W-1:0] data,
        input logic [MAX_W-1:0] acc,
        input logic             clr,
        input int unsigned      width
    );
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] d;
        logic [MAX_W-1:0] base;
        logic [MAX_W-1:0] sum;
        op_res_t          r;

        mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
        d    = data & mask;
        base = clr ? '0 : (acc & mask);
        // Carry out of the top bit is dropped by the mask.
        sum  = (base + d) & mask;

        r.result   = d;
        r.acc_next = base;
        case (op)
            OP_INV:  r.result = ~d & mask;
            OP_ACC: begin
                r.result   = sum;
                r.acc_next = sum;
            end
            // MSB wraps around to bit 0.
            OP_ROTL: r.result = ((d << 1) | (d >> (width - 1))) & mask;
            default: r.result = d;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bus_op_fifo_if.sv
// rtl/bus_op_fifo_if.sv - producer/consumer handshake bundle for bus_op_fifo
// Ports (master = producer+consumer side, slave = bus_op_fifo):
//   in_valid/in_ready/in_op/in_data  producer word and operation
//   acc_clr                          accumulator clear request
//   out_valid/out_ready/out_data     FIFO head towards the consumer
//   count                            FIFO occupancy
interface bus_op_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] in_data;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CW-1:0]    count;

    modport master (
        output in_valid, in_op, in_data, acc_clr, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  in_valid, in_op, in_data, acc_clr, out_ready,
        output in_ready, out_valid, out_data, count
    );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered head and occupancy count
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wr_en, wr_data  write request and word (ignored while full)
//   rd_en           pop request (ignored while empty)
//   rd_data         current head entry
//   count           occupancy, 0..DEPTH
//   full, empty     occupancy flags
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (do_wr) begin
            mem_d[wr_ptr_q] = wr_data;
            // DEPTH is a power of two, so the pointer wraps naturally.
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/bus_op_fifo.sv
// rtl/bus_op_fifo.sv - per-word bus operation (pass/invert/accumulate/rotate) into a FIFO
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   bus       slave side of bus_op_fifo_if (input word/op, acc_clr, FIFO head, count)
module bus_op_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    bus_op_fifo_if.slave   bus
);
    import bus_op_pkg::*;

    logic [WIDTH-1:0] acc_q, acc_d;
    op_res_t          res;
    logic             unused_res;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;

    always_comb begin
        res = apply_op(op_e'(bus.in_op), MAX_W'(bus.in_data), MAX_W'(acc_q),
                       bus.acc_clr, WIDTH);
    end

    // Only the low WIDTH bits of the function result are meaningful.
    assign unused_res = ^res;

    // Ready is held low during reset so nothing can be accepted on the reset edge.
    assign bus.in_ready  = !full && !rst;
    assign bus.out_valid = !empty;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    // A held word (in_valid without ready) must not touch the accumulator,
    // so the ACC update is gated by the actual push.
    always_comb begin
        acc_d = acc_q;
        if (bus.acc_clr) begin
            acc_d = '0;
        end
        if (push && (bus.in_op == OP_ACC)) begin
            acc_d = res.acc_next[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push),
        .wr_data (res.result[WIDTH-1:0]),
        .rd_en   (pop),
        .rd_data (bus.out_data),
        .count   (bus.count),
        .full    (full),
        .empty   (empty)
    );

endmodule

// File: tb/tb_bus_op_fifo.sv
// tb/tb_bus_op_fifo.sv - scoreboard bench for bus_op_fifo
module tb_bus_op_fifo;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bus_op_fifo_if #(.WIDTH(8), .DEPTH(4)) bus ();

    bus_op_fifo #(.WIDTH(8), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    logic [7:0] model_acc = 8'h00;
    bit         ok;

    localparam logic [1:0] PASS = 2'b00;
    localparam logic [1:0] INV  = 2'b01;
    localparam logic [1:0] ACC  = 2'b10;
    localparam logic [1:0] ROTL = 2'b11;

    // One clock of stimulus. Observes the DUT on the falling edge against the
    // scoreboard, then updates the model with what the rising edge will do.
    task automatic step(input logic v, input logic [1:0] op, input logic [7:0] d,
                        input logic clr, input logic ordy, output bit accepted);
        logic [7:0] e;
        int         n;
        bit         rdy_exp;
        bus.in_valid  = v;
        bus.in_op     = op;
        bus.in_data   = d;
        bus.acc_clr   = clr;
        bus.out_ready = ordy;
        accepted      = 1'b0;
        @(negedge clk);
        n       = exp_q.size();
        rdy_exp = !rst && (n < 4);
        checks++;
        if (bus.count !== 3'(n)) begin
            failures++;
            $display("FAIL count: got %0d expected %0d", bus.count, n);
        end
        checks++;
        if (bus.out_valid !== (n != 0)) begin
            failures++;
            $display("FAIL out_valid: got %b expected %b", bus.out_valid, (n != 0));
        end
        checks++;
        if (bus.in_ready !== rdy_exp) begin
            failures++;
            $display("FAIL in_ready: got %b expected %b", bus.in_ready, rdy_exp);
        end
        if (n > 0) begin
            checks++;
            if (bus.out_data !== exp_q[0]) begin
                failures++;
                $display("FAIL out_data: got %02h expected %02h", bus.out_data, exp_q[0]);
            end
        end
        if (rst) begin
            exp_q.delete();
            model_acc = 8'h00;
        end else begin
            if (ordy && n > 0) begin
                void'(exp_q.pop_front());
            end
            if (clr) begin
                model_acc = 8'h00;
            end
            if (v && rdy_exp) begin
                accepted = 1'b1;
                case (op)
                    PASS: e = d;
                    INV:  e = ~d;
                    ACC: begin
                        model_acc = model_acc + d;
                        e = model_acc;
                    end
                    default: e = {d[6:0], d[7]};
                endcase
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy, input int cycles);
        bit a;
        for (int i = 0; i < cycles; i++) begin
            step(1'b0, PASS, 8'h00, 1'b0, ordy, a);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_op     = PASS;
        bus.in_data   = 8'h00;
        bus.acc_clr   = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        idle(1'b0, 2);
        checks++;
        if (bus.out_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_out_data: got %02h expected 00", bus.out_data);
        end
        rst = 1'b0;
        idle(1'b0, 1);
    endtask

    task automatic test_pass_inv_rotl();
        step(1'b1, PASS, 8'hA5, 1'b0, 1'b1, ok);
        step(1'b1, INV,  8'hA5, 1'b0, 1'b1, ok);
        checks++;
        if (bus.out_data !== 8'h5A) begin
            failures++;
            $display("FAIL inv_literal: got %02h expected 5a", bus.out_data);
        end
        step(1'b1, ROTL, 8'h81, 1'b0, 1'b1, ok);
        checks++;
        if (bus.out_data !== 8'h03) begin
            failures++;
            $display("FAIL rotl_literal: got %02h expected 03", bus.out_data);
        end
        idle(1'b1, 2);
    endtask

    task automatic test_acc_wrap();
        step(1'b0, ACC, 8'h00, 1'b1, 1'b1, ok);
        step(1'b1, ACC, 8'hF0, 1'b0, 1'b1, ok);
        step(1'b1, ACC, 8'h20, 1'b0, 1'b1, ok);
        checks++;
        if (bus.out_data !== 8'h10 || bus.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL acc_wrap: got %02h/%b expected 10/1", bus.out_data, bus.out_valid);
        end
        idle(1'b1, 2);
    endtask

    task automatic test_full();
        for (int d = 1; d <= 4; d++) begin
            step(1'b1, PASS, 8'(d), 1'b0, 1'b0, ok);
        end
        checks++;
        if (bus.count !== 3'd4 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL full_state: got count=%0d in_ready=%b expected 4/0", bus.count, bus.in_ready);
        end
        step(1'b1, PASS, 8'h05, 1'b0, 1'b0, ok);
        step(1'b1, PASS, 8'h05, 1'b0, 1'b1, ok);
        checks++;
        if (bus.count !== 3'd3 || bus.out_data !== 8'h02) begin
            failures++;
            $display("FAIL full_pop: got count=%0d head=%02h expected 3/02", bus.count, bus.out_data);
        end
        step(1'b1, PASS, 8'h05, 1'b0, 1'b0, ok);
        checks++;
        if (bus.count !== 3'd4) begin
            failures++;
            $display("FAIL full_refill: got count=%0d expected 4", bus.count);
        end
        idle(1'b1, 5);
    endtask

    task automatic test_back_to_back();
        step(1'b1, PASS, 8'h11, 1'b0, 1'b0, ok);
        step(1'b1, PASS, 8'h22, 1'b0, 1'b0, ok);
        step(1'b1, PASS, 8'h33, 1'b0, 1'b1, ok);
        checks++;
        if (bus.count !== 3'd2 || bus.out_data !== 8'h22) begin
            failures++;
            $display("FAIL push_pop: got count=%0d head=%02h expected 2/22", bus.count, bus.out_data);
        end
        idle(1'b1, 3);
    endtask

    task automatic test_clr_and_reset();
        step(1'b0, ACC, 8'h00, 1'b1, 1'b1, ok);
        step(1'b1, ACC, 8'h10, 1'b0, 1'b1, ok);
        idle(1'b1, 1);
        step(1'b1, ACC, 8'h07, 1'b1, 1'b1, ok);
        checks++;
        if (bus.out_data !== 8'h07) begin
            failures++;
            $display("FAIL clr_collision: got %02h expected 07", bus.out_data);
        end
        step(1'b1, ACC, 8'h00, 1'b0, 1'b1, ok);
        idle(1'b1, 2);
        step(1'b1, PASS, 8'hAA, 1'b0, 1'b0, ok);
        step(1'b1, PASS, 8'hBB, 1'b0, 1'b0, ok);
        step(1'b1, PASS, 8'hCC, 1'b0, 1'b0, ok);
        rst = 1'b1;
        step(1'b1, PASS, 8'hDD, 1'b0, 1'b1, ok);
        rst = 1'b0;
        checks++;
        if (bus.count !== 3'd0 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: got count=%0d out_valid=%b expected 0/0", bus.count, bus.out_valid);
        end
        step(1'b1, ACC, 8'h01, 1'b0, 1'b1, ok);
        checks++;
        if (bus.out_data !== 8'h01) begin
            failures++;
            $display("FAIL acc_after_reset: got %02h expected 01", bus.out_data);
        end
        idle(1'b1, 2);
    endtask

    initial begin
        test_reset();
        test_pass_inv_rotl();
        test_acc_wrap();
        test_full();
        test_back_to_back();
        test_clr_and_reset();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d words left expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
